// File: rtl/note_display_scanner.sv
// Multi-channel seven-segment note display driver: frame-coherent input snapshots,
// PWM brightness and a per-channel decimal-point flash when a channel's note changes.
module note_display_scanner #(
  parameter int N_CH         = 3,
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_TO     = 100000,
  parameter int FLASH_FRAMES = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [4*N_CH-1:0]     notes_in,
  input  logic [N_CH-1:0]       enable_in,
  input  logic [3:0]            brightness_in,
  output logic [6:0]            cat_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] an_out
);

  localparam int SLOT_W = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FL_W   = $clog2(FLASH_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(COUNT_TO - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FL_W-1:0]   FL_LOAD   = FL_W'(FLASH_FRAMES);

  localparam logic [6:0] GLYPH_ZERO  = 7'b0111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_SHARP = 7'b1101101;

  if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
    $error("note_display_scanner: N_CH must be 1..8");
  end
  if (NUM_DIGITS < 3*N_CH - 1 || NUM_DIGITS > 32) begin : g_bad_num_digits
    $error("note_display_scanner: NUM_DIGITS must be >= 3*N_CH-1 and <= 32");
  end
  if (COUNT_TO < 2) begin : g_bad_count_to
    $error("note_display_scanner: COUNT_TO must be >= 2");
  end
  if (FLASH_FRAMES < 1) begin : g_bad_flash_frames
    $error("note_display_scanner: FLASH_FRAMES must be >= 1");
  end

  function automatic logic [6:0] letter_glyph(input logic [3:0] code);
    case (code)
      4'd0:        letter_glyph = GLYPH_ZERO;
      4'd1, 4'd2:  letter_glyph = 7'b0111001;
      4'd3, 4'd4:  letter_glyph = 7'b1011110;
      4'd5:        letter_glyph = 7'b1111001;
      4'd6, 4'd7:  letter_glyph = 7'b1110001;
      4'd8, 4'd9:  letter_glyph = 7'b0111101;
      4'd10, 4'd11: letter_glyph = 7'b1110111;
      4'd12:       letter_glyph = 7'b1111100;
      default:     letter_glyph = GLYPH_DASH;
    endcase
  endfunction

  function automatic logic [6:0] accidental_glyph(input logic [3:0] code);
    case (code)
      4'd0:                          accidental_glyph = GLYPH_ZERO;
      4'd2, 4'd4, 4'd7, 4'd9, 4'd11: accidental_glyph = GLYPH_SHARP;
      default:                       accidental_glyph = 7'b0000000;
    endcase
  endfunction

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [3:0]            pwm_q, pwm_d;
  logic [4*N_CH-1:0]     note_sh_q, note_sh_d;
  logic [N_CH-1:0]       en_sh_q, en_sh_d;
  logic [FL_W-1:0]       flash_q [N_CH];
  logic [FL_W-1:0]       flash_d [N_CH];
  logic [6:0]            cat_q, cat_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic       slot_wrap;
  logic       frame_wrap;
  logic [6:0] glyph;
  logic       dp_lit;
  logic       pwm_on;
  logic [3:0] new_code;

  always_comb begin
    slot_wrap  = (slot_q == SLOT_LAST);
    frame_wrap = slot_wrap && (digit_idx_q == IDX_LAST);

    slot_d      = slot_wrap ? '0 : slot_q + SLOT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_wrap) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    end
    pwm_d = pwm_q + 4'd1;

    note_sh_d = note_sh_q;
    en_sh_d   = en_sh_q;
    flash_d   = flash_q;
    new_code  = '0;
    if (frame_wrap) begin
      note_sh_d = notes_in;
      en_sh_d   = enable_in;
      for (int c = 0; c < N_CH; c++) begin
        new_code = notes_in[4*c +: 4];
        if (!enable_in[c]) begin
          flash_d[c] = '0;
        end else if (new_code != note_sh_q[4*c +: 4] && new_code >= 4'd1 && new_code <= 4'd12) begin
          flash_d[c] = FL_LOAD;
        end else if (flash_q[c] != '0) begin
          flash_d[c] = flash_q[c] - FL_W'(1);
        end
      end
    end

    // Channel c owns digit 3c (accidental) and 3c+1 (letter); everything else is blank.
    glyph  = '0;
    dp_lit = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (digit_idx_q == IDX_W'(3*c) && en_sh_q[c]) begin
        glyph = accidental_glyph(note_sh_q[4*c +: 4]);
      end
      if (digit_idx_q == IDX_W'(3*c + 1) && en_sh_q[c]) begin
        glyph  = letter_glyph(note_sh_q[4*c +: 4]);
        dp_lit = (flash_q[c] != '0);
      end
    end

    pwm_on = (pwm_q <= brightness_in);
    cat_d  = pwm_on ? ~glyph : 7'h7f;
    dp_d   = ~(pwm_on & dp_lit);
    an_d   = ~(NUM_DIGITS'(1) << digit_idx_q);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_q      <= '0;
      digit_idx_q <= '0;
      pwm_q       <= '0;
      note_sh_q   <= '0;
      en_sh_q     <= '0;
      for (int c = 0; c < N_CH; c++) flash_q[c] <= '0;
      cat_q       <= '1;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      slot_q      <= slot_d;
      digit_idx_q <= digit_idx_d;
      pwm_q       <= pwm_d;
      note_sh_q   <= note_sh_d;
      en_sh_q     <= en_sh_d;
      for (int c = 0; c < N_CH; c++) flash_q[c] <= flash_d[c];
      cat_q       <= cat_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign cat_out = cat_q;
  assign dp_out  = dp_q;
  assign an_out  = an_q;

endmodule

// File: tb/tb_note_display_scanner.sv
// Bench for note_display_scanner: two configurations driven side by side and compared
// every clock against a timeline model built from per-frame input snapshots.
module tb_note_display_scanner;

  localparam int CT   = 4;
  localparam int FF   = 3;
  localparam int MAXF = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] notes_a = '0;
  logic [2:0]  en_a = '0;
  logic [7:0]  notes_b = '0;
  logic [1:0]  en_b = '0;
  logic [3:0]  brightness = 4'd15;
  logic [6:0]  cat_a, cat_b;
  logic        dp_a, dp_b;
  logic [7:0]  an_a;
  logic [5:0]  an_b;

  note_display_scanner #(.N_CH(3), .NUM_DIGITS(8), .COUNT_TO(CT), .FLASH_FRAMES(FF)) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .notes_in(notes_a), .enable_in(en_a),
    .brightness_in(brightness), .cat_out(cat_a), .dp_out(dp_a), .an_out(an_a));

  note_display_scanner #(.N_CH(2), .NUM_DIGITS(6), .COUNT_TO(CT), .FLASH_FRAMES(FF)) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .notes_in(notes_b), .enable_in(en_b),
    .brightness_in(brightness), .cat_out(cat_b), .dp_out(dp_b), .an_out(an_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edges    = 0;
  logic [3:0] br_at_edge = 4'd15;

  bit [31:0] snap_notes [2][MAXF];
  bit [7:0]  snap_en    [2][MAXF];
  int nch_of [2] = '{3, 2};
  int nd_of  [2] = '{8, 6};

  string note_names [16] = '{"0", "C", "C#", "D", "D#", "E", "F", "F#",
                             "G", "G#", "A", "A#", "B", "-", "-", "-"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, edges, obs, exp);
  endtask

  function automatic logic [6:0] seg_of(input byte ch);
    case (ch)
      "C": return 7'b0111001;
      "D": return 7'b1011110;
      "E": return 7'b1111001;
      "F": return 7'b1110001;
      "G": return 7'b0111101;
      "A": return 7'b1110111;
      "B": return 7'b1111100;
      "0": return 7'b0111111;
      "-": return 7'b1000000;
      "S": return 7'b1101101;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic bit is_note(input int code);
    return code >= 1 && code <= 12;
  endfunction

  // Lit if a note change landed within the last FF frames and the channel stayed enabled since.
  function automatic bit flash_lit(input int d, input int f, input int c);
    for (int j = f; j >= 1 && j > f - FF; j--) begin
      if (!snap_en[d][j][c]) return 1'b0;
      if (snap_notes[d][j][4*c +: 4] != snap_notes[d][j-1][4*c +: 4] &&
          is_note(int'(snap_notes[d][j][4*c +: 4]))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic expected(input int d, output logic [6:0] cat, output logic dp, output logic [31:0] an);
    int n, dig, p, f, ch, r, code;
    string nm;
    logic [6:0] glyph;
    logic lit;
    logic [31:0] mask;
    mask = (32'd1 << nd_of[d]) - 32'd1;
    if (edges == 0) begin
      cat = 7'h7f; dp = 1'b1; an = mask;
      return;
    end
    n = edges - 1;
    dig = (n / CT) % nd_of[d];
    p = n % 16;
    f = n / (CT * nd_of[d]);
    ch = dig / 3;
    r = dig % 3;
    glyph = '0;
    lit = 1'b0;
    if (ch < nch_of[d] && r != 2 && snap_en[d][f][ch]) begin
      code = int'(snap_notes[d][f][4*ch +: 4]);
      nm = note_names[code];
      if (r == 1) begin
        glyph = seg_of(nm[0]);
        lit = flash_lit(d, f, ch);
      end else if (code == 0) begin
        glyph = seg_of("0");
      end else if (nm.len() == 2) begin
        glyph = seg_of("S");
      end
    end
    if (p <= int'(br_at_edge)) begin
      cat = ~glyph; dp = ~lit;
    end else begin
      cat = 7'h7f; dp = 1'b1;
    end
    an = mask & ~(32'd1 << dig);
  endtask

  task automatic check_outputs();
    logic [6:0] ec;
    logic ed;
    logic [31:0] ea;
    expected(0, ec, ed, ea);
    check("a_cat", 32'(cat_a), 32'(ec));
    check("a_dp", 32'(dp_a), 32'(ed));
    check("a_an", 32'(an_a), ea);
    expected(1, ec, ed, ea);
    check("b_cat", 32'(cat_b), 32'(ec));
    check("b_dp", 32'(dp_b), 32'(ed));
    check("b_an", 32'(an_b), ea);
  endtask

  // Called at a falling edge; advances one clock and checks at the next falling edge.
  task automatic tick();
    int ee;
    ee = edges + 1;
    br_at_edge = brightness;
    if (ee % (CT * nd_of[0]) == 0 && ee / (CT * nd_of[0]) < MAXF) begin
      snap_notes[0][ee / (CT * nd_of[0])] = 32'(notes_a);
      snap_en[0][ee / (CT * nd_of[0])]    = 8'(en_a);
    end
    if (ee % (CT * nd_of[1]) == 0 && ee / (CT * nd_of[1]) < MAXF) begin
      snap_notes[1][ee / (CT * nd_of[1])] = 32'(notes_b);
      snap_en[1][ee / (CT * nd_of[1])]    = 8'(en_b);
    end
    @(posedge clk);
    edges = ee;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int d = 0; d < 2; d++) begin
      snap_notes[d][0] = '0;
      snap_en[d][0]    = '0;
    end
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    #23;
    release_reset();

    notes_a = {4'hB, 4'h1, 4'h7};
    en_a = 3'b111;
    notes_b = {4'h3, 4'h9};
    en_b = 2'b11;
    brightness = 4'd15;
    run(4 * 32);

    run(11);
    notes_a[7:4] = 4'h5;
    notes_b[3:0] = 4'hA;
    run((FF + 3) * 32);

    notes_a = {4'h4, 4'hD, 4'h0};
    en_a = 3'b011;
    notes_b = {4'hF, 4'h0};
    run(3 * 32);

    brightness = 4'd3;
    run(2 * 32);

    run(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_cat_a", 32'(cat_a), 32'h7f);
    check("rst_an_a", 32'(an_a), 32'hff);
    check("rst_dp_a", 32'(dp_a), 32'h1);
    check("rst_an_b", 32'(an_b), 32'h3f);
    @(negedge clk);
    @(negedge clk);
    release_reset();
    brightness = 4'd15;
    run(2 * 32);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) notes_a = 12'($urandom);
      if ($urandom_range(0, 29) == 0) notes_b = 8'($urandom);
      if ($urandom_range(0, 99) == 0) en_a = 3'($urandom);
      if ($urandom_range(0, 99) == 0) en_b = 2'($urandom);
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_display_scanner.md
Name: note_display_scanner

Overview:
- Parametrised multi-channel note display driver for the board's seven-segment bank. Successor to the fixed three-finger note display.
- Shows N_CH note codes, each as a letter plus an accidental symbol, time-multiplexed across NUM_DIGITS anodes.
- Adds frame-coherent input snapshots, PWM brightness, a decimal-point "new note" flash per channel, and defined handling for invalid codes.
- Sits between the note classifier outputs and the top-level cat/an/dp pins.

Parameters:
N_CH, 3, number of note channels (1..8)
NUM_DIGITS, 8, number of anodes driven; must be >= 3*N_CH-1 and <= 32
COUNT_TO, 100000, clocks per digit slot; must be >= 2
FLASH_FRAMES, 64, full scan frames the dp flag stays lit after a channel's note changes; must be >= 1

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active-low
notes_in  input  4*N_CH  note codes; channel c is bits [4c+3:4c]; 0=none, 1..12=C..B, 13..15=invalid
enable_in  input  N_CH  per-channel display enable; 0 blanks both digits of that channel
brightness_in  input  4  PWM duty select
cat_out  output  7  segment cathodes, active-low, bit0=a .. bit6=g
dp_out  output  1  decimal point cathode, active-low
an_out  output  NUM_DIGITS  anodes, active-low, one-hot when lit

Behaviour:
- Clock is clk_in. Reset is asynchronous and active-low on rst_n_in; all state clears on assertion, independent of the clock.
- Reset values: cat_out all ones, dp_out=1, an_out all ones, slot counter 0, digit index 0, snapshots 0, flash counters 0.
- Slot counter: counts 0..COUNT_TO-1. At COUNT_TO-1 it wraps to 0 and the digit index advances by 1. The digit index wraps NUM_DIGITS-1 -> 0.
- Frame boundary: the digit index wrapping to 0. On that same cycle notes_in and enable_in are captured into shadow registers. All decoding uses the shadows, so there is no mid-frame tearing. The first snapshot happens at the first frame boundary after reset; until then the shadows are 0.
- Digit mapping (channel 0 is rightmost):
  - digit 3c: accidental of channel c
  - digit 3c+1: letter of channel c
  - digit 3c+2: blank separator
  - digits >= 3*N_CH: blank
- Letter glyphs, segments a..g active-high before inversion:
  - C=0111001, D=1011110, E=1111001, F=1110001, G=0111101, A=1110111, B=1111100
  - code 0 -> "0"=0111111
  - codes 13..15 -> dash=1000000
- Accidental glyphs:
  - "S"=1101101 for codes 2, 4, 7, 9, 11
  - "0" for code 0
  - blank for all other codes
- Disabled channel (shadow enable=0): both digits blank, dp off, flash counter forced to 0.
- Flash:
  - Trigger: at a frame boundary, a channel's new snapshot code differs from its previous snapshot, the new code is 1..12, and the channel is enabled.
  - Effect: that channel's flash counter loads FLASH_FRAMES, then decrements once per subsequent frame boundary, saturating at 0.
  - Output: dp is lit on the channel's letter digit while its counter is nonzero.
  - Retrigger during a flash reloads the counter to FLASH_FRAMES.
- PWM:
  - A free-running 4-bit counter increments every clock.
  - Segments and dp are driven only while pwm_cnt <= brightness_in, giving a duty of (brightness_in+1)/16. 15 means always on.
  - The anode stays asserted for the whole slot.
  - brightness_in is sampled each clock, not snapshotted.
- Output timing: an_out, cat_out and dp_out are registered, one clock after the digit index or PWM state they reflect. Blank digits still assert their anode, with all cathodes high.
- Changes to N_CH, NUM_DIGITS or COUNT_TO need no RTL edits. An out-of-range parameter triggers an elaboration-time assertion.

Test Plan:
1. Defaults, COUNT_TO=4, brightness_in=15, enable_in=111, notes_in={1011,0001,0111} (ch2=AS, ch1=C, ch0=FS).
   - an_out steps 11111110 -> 11111101 -> ... every 4 clocks.
   - Expected cat_out, digit by digit: d0 ~S, d1 ~F, d2 all ones, d3 all ones, d4 ~C, d5 all ones, d6 ~S, d7 ~A.
2. Change notes_in mid-frame.
   - Displayed glyphs are unchanged until the digit index next reaches 0, then all update together.
   - dp_out goes 0 on the changed channel's letter digit for exactly FLASH_FRAMES frames.
3. Edge codes: ch0=0000 shows "0","0"; ch1=1101 shows dash on the letter and blank accidental. Neither sets dp. enable_in[2]=0 blanks digits 6 and 7.
4. brightness_in=3.
   - Within each slot, cathodes are active for 4 of every 16 clocks, aligned to pwm_cnt 0..3.
   - The anode is held for the full slot.
5. Assert rst_n_in low between clock edges mid-slot.
   - Outputs go all ones immediately, without a clock edge.
   - After release, scanning restarts at digit 0 with a full COUNT_TO slot.
6. N_CH=2, NUM_DIGITS=6: digits 0-1 and 3-4 carry notes, 2 and 5 are blank. Index wraps 5 -> 0 and the snapshot occurs at the wrap.
